id_ex_stage_reg: RTL and testbench

//  ID/EX pipeline register for the 4-stage datapath. Captures the decoder's control bundle and register-file operands, and inserts bubbles.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/hazard_detect.sv | 25 ++
 rtl/id_ex_stage_reg.sv | 149 ++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: decoder control bundle layout, NOP bundle and
// instruction-type / branch-mode encodings. All enables in the bundle are
// active-low (0 = asserted).
package pipe_pkg;

   localparam int CTRL_W = 20;

   localparam logic [1:0] ITYPE_R   = 2'b00;
   localparam logic [1:0] ITYPE_MEM = 2'b01;
   localparam logic [1:0] ITYPE_IMM = 2'b10;
   localparam logic [1:0] ITYPE_BR  = 2'b11;
   localparam logic [1:0] BR_NONE   = 2'b11;

   // Field order is MSB first; bit offsets follow from the packing:
   // alu_op[19] alu_src[18] reg_write1_en[17] reg_write2_en[16]
   // write2_add_mux[15] mem_to_reg[14] mem_write_en[13] instr_type[12:11]
   // halt[10] alu_function[9:6] branch_mode[5:4] byte_op[3] pad[2:0]
   typedef struct packed {
      logic       alu_op;
      logic       alu_src;
      logic       reg_write1_en;
      logic       reg_write2_en;
      logic       write2_add_mux;
      logic       mem_to_reg;
      logic       mem_write_en;
      logic [1:0] instr_type;
      logic       halt;
      logic [3:0] alu_function;
      logic [1:0] branch_mode;
      logic       byte_op;
      logic [2:0] pad;
   } ctrl_t;

   localparam ctrl_t NOP_CTRL = '{
      alu_op:         1'b0,
      alu_src:        1'b0,
      reg_write1_en:  1'b1,
      reg_write2_en:  1'b1,
      write2_add_mux: 1'b0,
      mem_to_reg:     1'b1,
      mem_write_en:   1'b1,
      instr_type:     ITYPE_BR,
      halt:           1'b1,
      alu_function:   4'b0000,
      branch_mode:    BR_NONE,
      byte_op:        1'b1,
      pad:            3'b000
   };

   // A load is a memory-type instruction that writes its rt destination.
   function automatic logic is_load(input ctrl_t c);
      return (c.instr_type == ITYPE_MEM) && !c.reg_write2_en;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection for the ID/EX boundary. Purely combinational:
// raises stall_o when the load sitting in EX targets a register the ID
// instruction reads. Suppressed by a flush (ID instr is dead anyway), by a
// pending halt (upstream already frozen) and while in reset.
module hazard_detect import pipe_pkg::*; #(
   parameter int REG_AW = 4
) (
   input  logic              reset_n,
   input  ctrl_t             ex_ctrl_i,
   input  logic [REG_AW-1:0] ex_rt_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              flush_i,
   input  logic              halt_pend_i,
   output logic              stall_o
);

   // Compare the EX load destination against both ID source addresses.
   always_comb begin
      stall_o = reset_n && is_load(ex_ctrl_i)
                && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i))
                && !flush_i && !halt_pend_i;
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decoder bundle and operands, inserts
// bubbles for flush / load-use stall / halt drain, and sequences halt.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ST_RUN     | normal capture, halt not seen
//  ST_DRAIN   | halt passed to EX, cnt_q counts down, bubbles inserted
//  ST_HALTED  | pipeline drained, halted_o=1, ex_ctrl held NOP until reset
module id_ex_stage_reg import pipe_pkg::*; #(
   parameter int DATA_W    = 16,
   parameter int REG_AW    = 4,
   parameter int DRAIN_CYC = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc,
   input  logic              flush_i,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc,
   output logic              stall_o,
   output logic              halted_o
);

   localparam int CNT_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

   localparam logic [1:0] ST_RUN    = 2'b00;
   localparam logic [1:0] ST_DRAIN  = 2'b01;
   localparam logic [1:0] ST_HALTED = 2'b10;

   ctrl_t             id_c;
   ctrl_t             ctrl_q, ctrl_d;
   logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d;
   logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
   logic [DATA_W-1:0] imm_q, imm_d, pc_q, pc_d;
   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              halt_pend;
   logic              stall;

   assign id_c      = ctrl_t'(id_ctrl);
   // HALTED keeps halt_pend high so upstream stays frozen and bubbles continue.
   assign halt_pend = (state_q != ST_RUN);

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_detect (
      .reset_n     (reset_n),
      .ex_ctrl_i   (ctrl_q),
      .ex_rt_i     (rt_q),
      .id_rs_i     (id_rs),
      .id_rt_i     (id_rt),
      .flush_i     (flush_i),
      .halt_pend_i (halt_pend),
      .stall_o     (stall)
   );

   // Next-state: flush > stall > halt bubble > capture, plus drain countdown.
   always_comb begin
      ctrl_d  = ctrl_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      state_d = state_q;
      cnt_d   = cnt_q;

      if (flush_i) begin
         ctrl_d = NOP_CTRL;
         rs_d   = '0;
         rt_d   = '0;
         rd1_d  = '0;
         rd2_d  = '0;
         imm_d  = '0;
         pc_d   = '0;
      end else if (stall || halt_pend) begin
         // Operands are left as they were; a NOP ignores them.
         ctrl_d = NOP_CTRL;
      end else begin
         ctrl_d = id_c;
         rs_d   = id_rs;
         rt_d   = id_rt;
         rd1_d  = id_rd1;
         rd2_d  = id_rd2;
         imm_d  = id_imm;
         pc_d   = id_pc;
         if (!id_c.halt) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYC);
         end
      end

      if (state_q == ST_DRAIN) begin
         if (cnt_q == '0) begin
            state_d = ST_HALTED;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // Register update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_q  <= NOP_CTRL;
         rs_q    <= '0;
         rt_q    <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_ctrl  = ctrl_q;
   assign ex_rs    = rs_q;
   assign ex_rt    = rt_q;
   assign ex_rd1   = rd1_q;
   assign ex_rd2   = rd2_q;
   assign ex_imm   = imm_q;
   assign ex_pc    = pc_q;
   assign stall_o  = stall;
   assign halted_o = (state_q == ST_HALTED);

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios followed by random episodes,
// all compared against a cycle-indexed behavioural model of the stage.
module tb_id_ex_stage_reg;

   localparam int DATA_W    = 16;
   localparam int REG_AW    = 4;
   localparam int DRAIN_CYC = 3;

   localparam logic [19:0] NOP_C = 20'h37C38;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [19:0]       id_ctrl;
   logic [REG_AW-1:0] id_rs, id_rt;
   logic [DATA_W-1:0] id_rd1, id_rd2, id_imm, id_pc;
   logic              flush_i;
   logic [19:0]       ex_ctrl;
   logic [REG_AW-1:0] ex_rs, ex_rt;
   logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
   logic              stall_o, halted_o;

   id_ex_stage_reg #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .DRAIN_CYC(DRAIN_CYC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .id_ctrl(id_ctrl), .id_rs(id_rs),
      .id_rt(id_rt), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_pc(id_pc), .flush_i(flush_i), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs),
      .ex_rt(ex_rt), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_pc(ex_pc), .stall_o(stall_o), .halted_o(halted_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [19:0] mk(input bit aluop, input bit alusrc,
      input bit rw1, input bit rw2, input bit w2m, input bit m2r, input bit mw,
      input logic [1:0] it, input bit halt, input logic [3:0] fn,
      input logic [1:0] bm, input bit bo);
      return {aluop, alusrc, rw1, rw2, w2m, m2r, mw, it, halt, fn, bm, bo, 3'b000};
   endfunction

   // Model: what EX should hold, plus the cycle a halt was accepted (-1 none).
   logic [19:0]       m_ctrl = NOP_C;
   logic [REG_AW-1:0] m_rs = '0, m_rt = '0;
   logic [DATA_W-1:0] m_rd1 = '0, m_rd2 = '0, m_imm = '0, m_pc = '0;
   bit                m_data_ok = 1'b0;
   bit                m_addr_ok = 1'b0;
   int                halt_cap = -1;
   int                cyc = 0;

   function automatic bit exp_stall();
      bit ld;
      ld = (m_ctrl[12:11] == 2'b01) && (m_ctrl[16] == 1'b0);
      return reset_n && ld && ((m_rt == id_rs) || (m_rt == id_rt))
             && !flush_i && (halt_cap < 0);
   endfunction

   // One clock: check stall before the edge, advance the model, check outputs.
   task automatic step();
      bit es;
      bit eh;
      #1;
      es = exp_stall();
      chk("stall_o", {31'd0, stall_o}, {31'd0, es});
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
         m_ctrl = NOP_C; m_rs = '0; m_rt = '0;
         m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0;
         m_data_ok = 1'b1; m_addr_ok = 1'b1; halt_cap = -1;
      end else if (flush_i) begin
         m_ctrl = NOP_C; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0;
         m_data_ok = 1'b1; m_addr_ok = 1'b0;
      end else if (es || halt_cap >= 0) begin
         m_ctrl = NOP_C; m_data_ok = 1'b0; m_addr_ok = 1'b0;
      end else begin
         m_ctrl = id_ctrl; m_rs = id_rs; m_rt = id_rt;
         m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm; m_pc = id_pc;
         m_data_ok = 1'b1; m_addr_ok = 1'b1;
         if (id_ctrl[10] == 1'b0) halt_cap = cyc;
      end
      #1;
      eh = (halt_cap >= 0) && (cyc >= halt_cap + DRAIN_CYC + 1);
      chk("ex_ctrl", {12'd0, ex_ctrl}, {12'd0, m_ctrl});
      chk("halted_o", {31'd0, halted_o}, {31'd0, eh});
      if (m_data_ok) begin
         chk("ex_rd1", {16'd0, ex_rd1}, {16'd0, m_rd1});
         chk("ex_rd2", {16'd0, ex_rd2}, {16'd0, m_rd2});
         chk("ex_imm", {16'd0, ex_imm}, {16'd0, m_imm});
         chk("ex_pc",  {16'd0, ex_pc},  {16'd0, m_pc});
      end
      if (m_addr_ok) begin
         chk("ex_rs", {28'd0, ex_rs}, {28'd0, m_rs});
         chk("ex_rt", {28'd0, ex_rt}, {28'd0, m_rt});
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic [19:0] c, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [15:0] rd1, input logic [15:0] imm, input bit fl);
      id_ctrl = c; id_rs = rs; id_rt = rt; id_rd1 = rd1;
      id_rd2 = 16'($urandom); id_imm = imm; id_pc = 16'($urandom); flush_i = fl;
   endtask

   task automatic rand_inputs(input bit allow_halt);
      logic [19:0] c;
      c = 20'($urandom);
      if ($urandom_range(0, 2) == 0) begin
         c[12:11] = 2'b01;
         c[16]    = 1'b0;
      end
      c[10] = !(allow_halt && ($urandom_range(0, 29) == 0));
      id_ctrl = c;
      id_rs   = 4'($urandom_range(0, 3));
      id_rt   = 4'($urandom_range(0, 3));
      id_rd1  = 16'($urandom);
      id_rd2  = 16'($urandom);
      id_imm  = 16'($urandom);
      id_pc   = 16'($urandom);
      flush_i = ($urandom_range(0, 7) == 0);
   endtask

   logic [19:0] ORI, LW, ADD, SW, HLT;

   initial begin
      ORI = mk(0, 1, 1, 0, 0, 0, 1, 2'b10, 1, 4'b1001, 2'b11, 0);
      LW  = mk(0, 1, 1, 0, 0, 1, 1, 2'b01, 1, 4'b0000, 2'b11, 0);
      ADD = mk(0, 0, 0, 1, 0, 0, 1, 2'b00, 1, 4'b0001, 2'b11, 0);
      SW  = mk(0, 1, 1, 1, 0, 0, 0, 2'b01, 1, 4'b0000, 2'b11, 0);
      HLT = mk(0, 0, 1, 1, 0, 0, 1, 2'b11, 0, 4'b0000, 2'b11, 0);

      // Reset with random inputs.
      reset_n = 1'b0;
      rand_inputs(1);
      step();
      rand_inputs(1);
      step();
      chk("rst_ctrl", {12'd0, ex_ctrl}, {12'd0, NOP_C});
      chk("rst_rd1", {16'd0, ex_rd1}, 32'd0);
      chk("rst_halted", {31'd0, halted_o}, 32'd0);
      reset_n = 1'b1;

      // Pass-through.
      drive(ORI, 4'd1, 4'd2, 16'h00F0, 16'h000F, 0);
      step();
      chk("ori_ctrl", {12'd0, ex_ctrl}, {12'd0, ORI});
      chk("ori_rd1", {16'd0, ex_rd1}, 32'h00F0);
      chk("ori_imm", {16'd0, ex_imm}, 32'h000F);

      // Load-use, then release and capture of the held instruction.
      drive(LW, 4'd1, 4'd3, 16'h1111, 16'h0004, 0);
      step();
      drive(ADD, 4'd3, 4'd5, 16'h2222, 16'h0000, 0);
      #1 chk("lu_stall", {31'd0, stall_o}, 32'd1);
      step();
      chk("lu_bubble", {12'd0, ex_ctrl}, {12'd0, NOP_C});
      #1 chk("lu_release", {31'd0, stall_o}, 32'd0);
      step();
      chk("lu_capture", {12'd0, ex_ctrl}, {12'd0, ADD});
      drive(LW, 4'd1, 4'd3, 16'h1111, 16'h0004, 0);
      step();
      drive(ADD, 4'd4, 4'd5, 16'h2222, 16'h0000, 0);
      #1 chk("lu_nomatch", {31'd0, stall_o}, 32'd0);
      step();

      // Flush of a store; flush together with a load-use match.
      drive(SW, 4'd2, 4'd6, 16'h3333, 16'h0008, 1);
      step();
      chk("flush_mwen", {31'd0, ex_ctrl[13]}, 32'd1);
      chk("flush_rd1", {16'd0, ex_rd1}, 32'd0);
      drive(LW, 4'd1, 4'd3, 16'h1111, 16'h0004, 0);
      step();
      drive(ADD, 4'd3, 4'd5, 16'h2222, 16'h0000, 1);
      #1 chk("flush_stall", {31'd0, stall_o}, 32'd0);
      step();
      chk("flush_stall_nop", {12'd0, ex_ctrl}, {12'd0, NOP_C});

      // Halt squashed by flush.
      drive(HLT, 4'd0, 4'd0, 16'h0, 16'h0, 1);
      step();
      drive(ADD, 4'd1, 4'd2, 16'h4444, 16'h0, 0);
      step();
      chk("halt_squash", {12'd0, ex_ctrl}, {12'd0, ADD});

      // Halt drain timing and stickiness.
      drive(HLT, 4'd0, 4'd0, 16'h0, 16'h0, 0);
      step();
      chk("halt_pass", {12'd0, ex_ctrl}, {12'd0, HLT});
      for (int k = 1; k <= DRAIN_CYC + 4; k++) begin
         rand_inputs(0);
         step();
         chk("halt_timing", {31'd0, halted_o}, {31'd0, (k >= DRAIN_CYC + 1)});
      end
      chk("halt_sticky_nop", {12'd0, ex_ctrl}, {12'd0, NOP_C});

      // Reset one cycle into the drain.
      reset_n = 1'b0;
      rand_inputs(0);
      step();
      reset_n = 1'b1;
      drive(HLT, 4'd0, 4'd0, 16'h0, 16'h0, 0);
      step();
      reset_n = 1'b0;
      rand_inputs(0);
      step();
      reset_n = 1'b1;
      drive(ORI, 4'd1, 4'd2, 16'h00F0, 16'h000F, 0);
      step();
      chk("rst_drain_resume", {12'd0, ex_ctrl}, {12'd0, ORI});
      for (int k = 0; k < DRAIN_CYC + 3; k++) begin
         rand_inputs(0);
         step();
      end
      chk("rst_drain_halted", {31'd0, halted_o}, 32'd0);

      // Random episodes, each starting from reset.
      for (int ep = 0; ep < 20; ep++) begin
         reset_n = 1'b0;
         rand_inputs(1);
         step();
         for (int c = 0; c < 60; c++) begin
            rand_inputs(1);
            reset_n = ($urandom_range(0, 79) != 0);
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
